stage_mem_lsu: RTL and testbench

STAGE_MEM_LSU -- requirements
Module: stage_mem_lsu

---
 rtl/mem_lsu_pkg.sv | 74 +++++++
 rtl/mem_load_align.sv | 30 +++
 rtl/stage_mem_lsu.sv | 196 +++++++++++++++++++
 tb/tb_stage_mem_lsu.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: op codes, memdev
// command codes, exception codes, FSM states and the op decoder.
package mem_lsu_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_LWU  = 4'd6,
        OP_LD   = 4'd7,
        OP_SB   = 4'd8,
        OP_SH   = 4'd9,
        OP_SW   = 4'd10,
        OP_SD   = 4'd11
    } mem_op_e;

    typedef enum logic [1:0] {
        MOPT_NONE  = 2'd0,
        MOPT_READ  = 2'd1,
        MOPT_WRITE = 2'd2
    } memdev_opt_e;

    typedef enum logic [1:0] {
        EXC_LOAD_MISALIGN  = 2'd0,
        EXC_STORE_MISALIGN = 2'd1,
        EXC_BUS_TIMEOUT    = 2'd2
    } exc_code_e;

    typedef enum logic [1:0] {
        READY       = 2'd0,
        WAIT_BUSY   = 2'd1,
        WAIT_UNBUSY = 2'd2
    } lsu_state_e;

    // Access size as log2(bytes).
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_e;

    typedef struct packed {
        logic      mem;
        logic      store;
        mem_size_e size;
        logic      sign;
    } mem_dec_t;

    // 64-bit-only ops decode as non-memory when the datapath is 32 bits wide.
    function automatic mem_dec_t decode_op(input logic [3:0] op, input logic wide);
        mem_dec_t d;
        d = '{mem: 1'b0, store: 1'b0, size: SZ_B, sign: 1'b0};
        case (op)
            OP_LB:   d = '{mem: 1'b1, store: 1'b0, size: SZ_B, sign: 1'b1};
            OP_LBU:  d = '{mem: 1'b1, store: 1'b0, size: SZ_B, sign: 1'b0};
            OP_LH:   d = '{mem: 1'b1, store: 1'b0, size: SZ_H, sign: 1'b1};
            OP_LHU:  d = '{mem: 1'b1, store: 1'b0, size: SZ_H, sign: 1'b0};
            OP_LW:   d = '{mem: 1'b1, store: 1'b0, size: SZ_W, sign: 1'b1};
            OP_LWU:  d = '{mem: wide, store: 1'b0, size: SZ_W, sign: 1'b0};
            OP_LD:   d = '{mem: wide, store: 1'b0, size: SZ_D, sign: 1'b0};
            OP_SB:   d = '{mem: 1'b1, store: 1'b1, size: SZ_B, sign: 1'b0};
            OP_SH:   d = '{mem: 1'b1, store: 1'b1, size: SZ_H, sign: 1'b0};
            OP_SW:   d = '{mem: 1'b1, store: 1'b1, size: SZ_W, sign: 1'b0};
            OP_SD:   d = '{mem: wide, store: 1'b1, size: SZ_D, sign: 1'b0};
            default: d = '{mem: 1'b0, store: 1'b0, size: SZ_B, sign: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane extraction: shifts the addressed bytes down to bit 0 and
// sign- or zero-extends them to the full register width.
module mem_load_align
    import mem_lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]             data_in,
    input  logic [$clog2(DATA_W/8)-1:0]   offset,
    input  mem_size_e                     size,
    input  logic                          sign,
    output logic [DATA_W-1:0]             data_out
);

    logic [DATA_W-1:0] shifted;
    int                nbits;

    always_comb begin
        shifted  = data_in >> {offset, 3'b000};
        nbits    = 8 << size;
        if (nbits > DATA_W)
            nbits = DATA_W;
        data_out = shifted;
        for (int i = 0; i < DATA_W; i++) begin
            if (i >= nbits)
                data_out[i] = sign & shifted[nbits-1];
        end
    end

endmodule

// File: rtl/stage_mem_lsu.sv
// MEM pipeline stage: issues loads/stores to a busy-handshake memory device,
// writes results back, and raises a bus-timeout exception on a hung device.
// Optional build macro MEM_ALIGN_CHECK_EN traps misaligned H/W/D accesses
// instead of silently forcing them aligned.
module stage_mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int REGADDR_W = 5,
    parameter int TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic [REGADDR_W-1:0]   ex_reg_addr,
    input  logic [DATA_W-1:0]      ex_alu_result,
    input  logic [ADDR_W-1:0]      ex_mem_addr,
    input  logic [3:0]             ex_mem_op,
    output logic [REGADDR_W-1:0]   wb_reg_addr,
    output logic [DATA_W-1:0]      wb_reg_data,
    output logic                   set_stall,
    output logic [ADDR_W-1:0]      memdev_addr,
    output logic [DATA_W-1:0]      memdev_data_out,
    output logic [DATA_W/8-1:0]    memdev_be,
    output logic [1:0]             memdev_opt,
    input  logic [DATA_W-1:0]      memdev_data_in,
    input  logic                   memdev_busy,
    output logic                   exc_valid,
    output logic [1:0]             exc_code,
    output logic [ADDR_W-1:0]      exc_badaddr
);

    localparam int BE_W    = DATA_W / 8;
    localparam int OFF_W   = $clog2(BE_W);
    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    lsu_state_e           state, state_nx;
    logic [CNT_W-1:0]     wait_cnt;
    logic [REGADDR_W-1:0] rd_q;
    logic [OFF_W-1:0]     off_q;
    mem_size_e            size_q;
    logic                 sign_q, store_q;
    logic [ADDR_W-1:0]    req_addr_q;

    mem_dec_t             dec;
    logic [OFF_W-1:0]     off_raw, size_mask, off_eff;
    logic                 misalign, timeout_hit, accept, complete, tmo;
    logic [BE_W-1:0]      be_nx;
    logic [DATA_W-1:0]    st_data, ld_data;

    assign dec       = decode_op(ex_mem_op, DATA_W >= 64);
    assign off_raw   = ex_mem_addr[OFF_W-1:0];
    assign size_mask = OFF_W'((32'd1 << dec.size) - 32'd1);
    assign off_eff   = off_raw & ~size_mask;
    assign be_nx     = BE_W'((32'd1 << (32'd1 << dec.size)) - 32'd1) << off_eff;
    assign set_stall = (state != READY);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = dec.mem && |(off_raw & size_mask);
`else
    assign misalign = 1'b0;
`endif

    assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == CNT_W'(TO_LAST));

    // Store data is replicated into every lane so the device only needs byte enables.
    always_comb begin
        st_data = ex_alu_result;
        for (int i = 0; i < BE_W; i++) begin
            case (dec.size)
                SZ_B:    st_data[i*8 +: 8] = ex_alu_result[7:0];
                SZ_H:    st_data[i*8 +: 8] = ex_alu_result[(i%2)*8 +: 8];
                SZ_W:    st_data[i*8 +: 8] = ex_alu_result[(i%4)*8 +: 8];
                default: st_data[i*8 +: 8] = ex_alu_result[i*8 +: 8];
            endcase
        end
    end

    mem_load_align #(.DATA_W(DATA_W)) u_load_align (
        .data_in  (memdev_data_in),
        .offset   (off_q),
        .size     (size_q),
        .sign     (sign_q),
        .data_out (ld_data)
    );

    // A busy fall coinciding with the timeout completes the access.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        complete = 1'b0;
        tmo      = 1'b0;
        case (state)
            READY: begin
                if (!stall && dec.mem && !misalign) begin
                    state_nx = WAIT_BUSY;
                    accept   = 1'b1;
                end
            end
            WAIT_BUSY: begin
                if (timeout_hit) begin
                    state_nx = READY;
                    tmo      = 1'b1;
                end else if (memdev_busy) begin
                    state_nx = WAIT_UNBUSY;
                end
            end
            WAIT_UNBUSY: begin
                if (!memdev_busy) begin
                    state_nx = READY;
                    complete = 1'b1;
                end else if (timeout_hit) begin
                    state_nx = READY;
                    tmo      = 1'b1;
                end
            end
            default: state_nx = READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= READY;
            wait_cnt        <= '0;
            wb_reg_addr     <= '0;
            wb_reg_data     <= '0;
            memdev_addr     <= '0;
            memdev_data_out <= '0;
            memdev_be       <= '0;
            memdev_opt      <= MOPT_NONE;
            exc_valid       <= 1'b0;
            exc_code        <= '0;
            exc_badaddr     <= '0;
            rd_q            <= '0;
            off_q           <= '0;
            size_q          <= SZ_B;
            sign_q          <= 1'b0;
            store_q         <= 1'b0;
            req_addr_q      <= '0;
        end else begin
            state       <= state_nx;
            wb_reg_addr <= '0;
            exc_valid   <= 1'b0;
            if (accept)
                wait_cnt <= '0;
            else if (state != READY)
                wait_cnt <= wait_cnt + 1'b1;

            case (state)
                READY: begin
                    if (!stall) begin
                        if (!dec.mem) begin
                            wb_reg_addr <= ex_reg_addr;
                            wb_reg_data <= ex_alu_result;
                        end else if (misalign) begin
                            // Back-to-back faults are dropped; the pipeline is flushing on the first.
                            if (!exc_valid) begin
                                exc_valid   <= 1'b1;
                                exc_code    <= dec.store ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN;
                                exc_badaddr <= ex_mem_addr;
                            end
                        end else begin
                            memdev_addr     <= {ex_mem_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            memdev_opt      <= dec.store ? MOPT_WRITE : MOPT_READ;
                            memdev_be       <= be_nx;
                            memdev_data_out <= st_data;
                            rd_q            <= ex_reg_addr;
                            off_q           <= off_eff;
                            size_q          <= dec.size;
                            sign_q          <= dec.sign;
                            store_q         <= dec.store;
                            req_addr_q      <= ex_mem_addr;
                        end
                    end
                end
                default: begin
                    if (complete) begin
                        memdev_opt <= MOPT_NONE;
                        if (!store_q) begin
                            wb_reg_addr <= rd_q;
                            wb_reg_data <= ld_data;
                        end
                    end else if (tmo) begin
                        memdev_opt  <= MOPT_NONE;
                        exc_valid   <= 1'b1;
                        exc_code    <= EXC_BUS_TIMEOUT;
                        exc_badaddr <= req_addr_q;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_mem_lsu.sv
// Scoreboard bench for stage_mem_lsu: directed ops push expected writebacks,
// memdev requests and exceptions; a negedge monitor pops and compares them.
module tb_stage_mem_lsu;
    import mem_lsu_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic [RW-1:0] ex_reg_addr = '0;
    logic [DW-1:0] ex_alu_result = '0;
    logic [AW-1:0] ex_mem_addr = '0;
    logic [3:0]    ex_mem_op = 4'd0;
    logic [RW-1:0] wb_reg_addr;
    logic [DW-1:0] wb_reg_data;
    logic          set_stall;
    logic [AW-1:0] memdev_addr;
    logic [DW-1:0] memdev_data_out;
    logic [3:0]    memdev_be;
    logic [1:0]    memdev_opt;
    logic [DW-1:0] memdev_data_in = '0;
    logic          memdev_busy = 1'b0;
    logic          exc_valid;
    logic [1:0]    exc_code;
    logic [AW-1:0] exc_badaddr;

    stage_mem_lsu #(.DATA_W(DW), .ADDR_W(AW), .REGADDR_W(RW), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .ex_reg_addr(ex_reg_addr), .ex_alu_result(ex_alu_result),
        .ex_mem_addr(ex_mem_addr), .ex_mem_op(ex_mem_op),
        .wb_reg_addr(wb_reg_addr), .wb_reg_data(wb_reg_data), .set_stall(set_stall),
        .memdev_addr(memdev_addr), .memdev_data_out(memdev_data_out),
        .memdev_be(memdev_be), .memdev_opt(memdev_opt),
        .memdev_data_in(memdev_data_in), .memdev_busy(memdev_busy),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_badaddr(exc_badaddr)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [RW-1:0] rd; logic [DW-1:0] data; } wb_t;
    typedef struct packed { logic [1:0] code; logic [AW-1:0] addr; } exc_t;
    typedef struct packed { logic [AW-1:0] addr; logic [1:0] opt; logic [3:0] be; logic [DW-1:0] data; } req_t;

    wb_t  wb_q[$];
    exc_t exc_q[$];
    req_t req_q[$];
    wb_t  we;
    exc_t ee;
    req_t re;

    int   checks = 0;
    int   failures = 0;
    int   stall_run = 0;
    int   last_run = 0;
    logic prev_exc = 1'b0;
    logic [1:0] prev_opt = 2'd0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: compare whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        if (rst) begin
            stall_run = 0;
            prev_exc  = 1'b0;
            prev_opt  = 2'd0;
        end else begin
            if (wb_reg_addr != '0) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", 64'(wb_reg_addr), 64'd0);
                end else begin
                    we = wb_q.pop_front();
                    chk("wb_addr", 64'(wb_reg_addr), 64'(we.rd));
                    chk("wb_data", 64'(wb_reg_data), 64'(we.data));
                end
            end
            if (exc_valid) begin
                chk("exc_single_pulse", 64'(prev_exc), 64'd0);
                if (exc_q.size() == 0) begin
                    chk("exc_unexpected", 64'(exc_code), 64'hFF);
                end else begin
                    ee = exc_q.pop_front();
                    chk("exc_code", 64'(exc_code), 64'(ee.code));
                    chk("exc_badaddr", 64'(exc_badaddr), 64'(ee.addr));
                end
            end
            if (memdev_opt != 2'd0 && prev_opt == 2'd0) begin
                if (req_q.size() == 0) begin
                    chk("req_unexpected", 64'(memdev_opt), 64'd0);
                end else begin
                    re = req_q.pop_front();
                    chk("req_addr", 64'(memdev_addr), 64'(re.addr));
                    chk("req_opt", 64'(memdev_opt), 64'(re.opt));
                    chk("req_be", 64'(memdev_be), 64'(re.be));
                    chk("req_data", 64'(memdev_data_out), 64'(re.data));
                end
            end
            if (set_stall) begin
                stall_run++;
            end else if (stall_run != 0) begin
                last_run  = stall_run;
                stall_run = 0;
            end
            prev_exc = exc_valid;
            prev_opt = memdev_opt;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic issue(input logic [3:0] op, input logic [RW-1:0] rd,
                         input logic [DW-1:0] alu, input logic [AW-1:0] addr);
        ex_mem_op     = op;
        ex_reg_addr   = rd;
        ex_alu_result = alu;
        ex_mem_addr   = addr;
        step();
        ex_mem_op     = OP_NONE;
        ex_reg_addr   = '0;
        ex_alu_result = '0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (set_stall && n < 400) begin
            step();
            n++;
        end
        if (set_stall)
            chk("ready_bound", 64'(set_stall), 64'd0);
    endtask

    // Device model: idle dly cycles, busy for len cycles, then return rdata.
    task automatic device(input int dly, input int len, input logic [DW-1:0] rdata);
        repeat (dly) step();
        memdev_busy = 1'b1;
        repeat (len) step();
        memdev_busy    = 1'b0;
        memdev_data_in = rdata;
        wait_ready();
    endtask

    task automatic push_req(input logic [AW-1:0] a, input logic [1:0] o, input logic [3:0] b, input logic [DW-1:0] d);
        req_q.push_back('{addr: a, opt: o, be: b, data: d});
    endtask

    task automatic push_wb(input logic [RW-1:0] r, input logic [DW-1:0] d);
        wb_q.push_back('{rd: r, data: d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        chk("rst_wb_addr", 64'(wb_reg_addr), 64'd0);
        chk("rst_wb_data", 64'(wb_reg_data), 64'd0);
        chk("rst_opt", 64'(memdev_opt), 64'd0);
        chk("rst_be", 64'(memdev_be), 64'd0);
        chk("rst_maddr", 64'(memdev_addr), 64'd0);
        chk("rst_mdata", 64'(memdev_data_out), 64'd0);
        chk("rst_exc", 64'(exc_valid), 64'd0);
        chk("rst_stall", 64'(set_stall), 64'd0);
        rst = 1'b0;
        idle(1);

        // Non-memory op: one-cycle register passthrough.
        push_wb(5'd7, 32'h55);
        issue(OP_NONE, 5'd7, 32'h55, 32'h0);
        chk("none_latency", 64'(wb_reg_addr), 64'd7);

        // Stall holds data and suppresses writeback and issue.
        stall = 1'b1;
        issue(OP_NONE, 5'd9, 32'h66, 32'h0);
        chk("stall_wb_addr", 64'(wb_reg_addr), 64'd0);
        chk("stall_wb_data", 64'(wb_reg_data), 64'h55);
        issue(OP_LW, 5'd9, 32'h0, 32'h100);
        chk("stall_no_issue", 64'(memdev_opt), 64'd0);
        chk("stall_no_wait", 64'(set_stall), 64'd0);
        stall = 1'b0;
        idle(1);

        push_req(32'h100, MOPT_READ, 4'b1111, 32'h0);
        push_wb(5'd3, 32'hDEADBEEF);
        issue(OP_LW, 5'd3, 32'h0, 32'h100);
        device(1, 2, 32'hDEADBEEF);
        idle(2);
        chk("lw_stall_cycles", 64'(last_run), 64'd4);

        push_req(32'h100, MOPT_READ, 4'b1000, 32'h0);
        push_wb(5'd4, 32'hFFFFFF80);
        issue(OP_LB, 5'd4, 32'h0, 32'h103);
        device(1, 1, 32'h80112233);
        idle(2);

        push_req(32'h100, MOPT_READ, 4'b1000, 32'h0);
        push_wb(5'd5, 32'h00000080);
        issue(OP_LBU, 5'd5, 32'h0, 32'h103);
        device(1, 1, 32'h80112233);
        idle(2);

        push_req(32'h100, MOPT_READ, 4'b1100, 32'h0);
        push_wb(5'd6, 32'hFFFF8011);
        issue(OP_LH, 5'd6, 32'h0, 32'h102);
        device(1, 1, 32'h80112233);
        idle(2);

        push_req(32'h100, MOPT_READ, 4'b0011, 32'h0);
        push_wb(5'd8, 32'h00002233);
        issue(OP_LHU, 5'd8, 32'h0, 32'h100);
        device(1, 1, 32'h80112233);
        idle(2);

        // Stores: no writeback expected, so any wb is flagged by the monitor.
        push_req(32'h100, MOPT_WRITE, 4'b1100, 32'hABCDABCD);
        issue(OP_SH, 5'd10, 32'h1234ABCD, 32'h102);
        device(1, 1, 32'h0);
        idle(2);
        chk("sh_wb_addr", 64'(wb_reg_addr), 64'd0);

        push_req(32'h100, MOPT_WRITE, 4'b0010, 32'hA5A5A5A5);
        issue(OP_SB, 5'd11, 32'h000000A5, 32'h101);
        device(0, 1, 32'h0);
        idle(2);

        // LD on a 32-bit datapath behaves as a non-memory op.
        push_wb(5'd12, 32'h77);
        issue(OP_LD, 5'd12, 32'h77, 32'h100);
        chk("ld32_no_wait", 64'(set_stall), 64'd0);
        idle(2);

        // Device never answers: bus timeout after 255 wait cycles.
        push_req(32'h200, MOPT_READ, 4'b1111, 32'h0);
        exc_q.push_back('{code: 2'd2, addr: 32'h200});
        issue(OP_LW, 5'd13, 32'h0, 32'h200);
        wait_ready();
        idle(2);
        chk("timeout_cycles", 64'(last_run), 64'd255);

        // Busy falls in the same cycle the timeout would fire: completion wins.
        push_req(32'h300, MOPT_READ, 4'b1111, 32'h0);
        push_wb(5'd14, 32'h0BADF00D);
        issue(OP_LW, 5'd14, 32'h0, 32'h300);
        device(0, 254, 32'h0BADF00D);
        idle(2);
        chk("race_cycles", 64'(last_run), 64'd255);

`ifdef MEM_ALIGN_CHECK_EN
        exc_q.push_back('{code: 2'd0, addr: 32'h101});
        issue(OP_LW, 5'd15, 32'h0, 32'h101);
        chk("mis_ld_opt", 64'(memdev_opt), 64'd0);
        chk("mis_ld_stall", 64'(set_stall), 64'd0);
        chk("mis_ld_wb", 64'(wb_reg_addr), 64'd0);
        idle(1);
        exc_q.push_back('{code: 2'd1, addr: 32'h102});
        issue(OP_SW, 5'd15, 32'hCAFEF00D, 32'h102);
        chk("mis_st_opt", 64'(memdev_opt), 64'd0);
        idle(2);
`else
        push_req(32'h100, MOPT_READ, 4'b1111, 32'h0);
        push_wb(5'd15, 32'h11223344);
        issue(OP_LW, 5'd15, 32'h0, 32'h101);
        device(1, 1, 32'h11223344);
        idle(2);
        push_req(32'h100, MOPT_WRITE, 4'b1111, 32'hCAFEF00D);
        issue(OP_SW, 5'd15, 32'hCAFEF00D, 32'h102);
        device(1, 1, 32'h0);
        idle(2);
`endif

        // Reset while in WAIT_UNBUSY aborts silently.
        push_req(32'h400, MOPT_READ, 4'b1111, 32'h0);
        issue(OP_LW, 5'd16, 32'h0, 32'h400);
        memdev_busy = 1'b1;
        idle(2);
        rst = 1'b1;
        step();
        chk("rstmid_stall", 64'(set_stall), 64'd0);
        chk("rstmid_wb", 64'(wb_reg_addr), 64'd0);
        chk("rstmid_exc", 64'(exc_valid), 64'd0);
        chk("rstmid_opt", 64'(memdev_opt), 64'd0);
        rst = 1'b0;
        memdev_busy = 1'b0;
        idle(2);

        push_wb(5'd17, 32'h99);
        issue(OP_NONE, 5'd17, 32'h99, 32'h0);
        idle(3);

        chk("wb_q_empty", 64'(wb_q.size()), 64'd0);
        chk("exc_q_empty", 64'(exc_q.size()), 64'd0);
        chk("req_q_empty", 64'(req_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
